shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
Sequential radix-2 shift-and-add multiplier. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands. It is the stage directly upstream of the Barrett reducer: its product output feeds the reducer's 2*P_WIDTH input, and its done level gates the reducer's start. It is sized for field elements, using one adder and no DSP inference.

Parameters:
- WIDTH, default P_WIDTH (from elliptic_curve_structs), operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk      input   1          rising-edge clock
- reset    input   1          asynchronous, active-high reset
- start    input   1          request to multiply a and b; only sampled when not busy
- a        input   WIDTH      multiplicand; latched on an accepted start
- b        input   WIDTH      multiplier; latched on an accepted start
- busy     output  1          high while an operation is in progress (state RUN)
- done     output  1          level; high from completion until the next accepted start
- ab       output  2*WIDTH    product a*b; valid and stable while done=1

Behaviour:
- Reset is asynchronous and active-high. On assertion: state=IDLE; ab=0; done=0; busy=0; internal accumulator, shift registers and counter cleared.
- Reset mid-operation aborts the operation and discards it. The first edge after reset release behaves as IDLE.
- States:
  - IDLE: no result yet.
  - RUN: iterating.
  - DONE: result held.
- Start acceptance:
  - start is accepted on an edge where state is IDLE or DONE.
  - On acceptance: mcand <= zero-extended a (2*WIDTH bits); mplier <= b; acc <= 0; cnt <= 0; done <= 0; busy <= 1; state <= RUN.
  - ab keeps its old value until completion.
- start while in RUN is ignored. Operand changes during RUN have no effect.
- RUN step, one per edge:
  - acc_next = acc + (mplier[0] ? mcand : 0), modulo 2^(2*WIDTH). No overflow is possible.
  - mcand <<= 1; mplier >>= 1; cnt++.
- Completion:
  - The step with cnt == WIDTH-1 writes ab <= acc_next, done <= 1, busy <= 0, state <= DONE.
  - Latency: the accepted start edge is E0; done and ab become visible after edge E_WIDTH, i.e. exactly WIDTH cycles.
- DONE:
  - Holds ab and done indefinitely.
  - A start in DONE is accepted on that same edge (back-to-back), so done falls for the whole new RUN.
- Simultaneous start and completion cannot occur, because start is ignored in RUN.
- The counter is $clog2(WIDTH+1) bits and never wraps within an operation.
- The consumer is expected to launch the reducer on the rising edge of done, or to treat done as an enable level.

Optional Feature:
- Macro: SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN.
- Defined: a RUN step also completes when the post-shift mplier is 0, writing ab <= acc_next as for normal completion.
  - b=0 or b=1 completes after edge E1.
  - In general, latency = max(1, index of the highest set bit of b + 1) cycles.
- Undefined: latency is always exactly WIDTH cycles, independent of data (constant time, side-channel safe). This is the default build.

Decomposition:
- P_WIDTH comes from elliptic_curve_structs; add no new types. The state enum (IDLE/RUN/DONE) is local to the module.
- No sub-module: the single adder and the shifters live inline in one always_ff block, with the next-state logic in an always_comb block.

Test Plan (WIDTH=8 bench, plus one default-width run):
- a=8'hFF, b=8'hFF, one-cycle start → busy=1 for 8 cycles; done rises exactly 8 cycles after the start edge; ab=16'hFE01; ab and done hold for 20 idle cycles.
- a=8'h12, b=8'h34 → ab=16'h03A8. Then a=0, b=8'hA5 → ab=16'h0000 after 8 cycles, with the macro undefined.
- Start a=3, b=5; pulse start with a=7, b=7 at cycle 3 of RUN → the second start is ignored; ab=16'h000F at cycle 8; done stays high afterwards.
- Back-to-back: hold start high with a=2, b=9 through completion → done high for exactly one cycle (ab=16'h0012); the next op is accepted on the same edge; after 8 more cycles ab=16'h0012 with done high.
- Reset asserted asynchronously mid-cycle at RUN cycle 4 → ab=0, done=0 and busy=0 immediately, without waiting for a clock edge. After release, a=8'h10, b=8'h10 → ab=16'h0100 after 8 cycles.
- With SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN: a=8'hAB, b=1 → done after 1 cycle, ab=16'h00AB; b=8'h08 → done after 4 cycles, ab=16'h0558. At default width, 1000 random operand pairs are checked against a reference a*b, in both builds.

Source files
------------

// File: rtl/elliptic_curve_structs.sv
// Shared field-element sizing for the elliptic-curve datapath.
package elliptic_curve_structs;
    localparam int P_WIDTH = 64;
endpackage

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add multiplier producing a full 2*WIDTH-bit product, one adder.
// Build option: SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN ends a run once the multiplier has no set bits left.
//
// state | meaning
// IDLE  | no result yet
// RUN   | iterating, one partial product per clock
// DONE  | result held on ab, done high
module shift_add_multiplier
    import elliptic_curve_structs::*;
#(
    parameter int WIDTH = P_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   ab
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, acc_q, ab_q, acc_next;
    logic [WIDTH-1:0]   mplier_q, mplier_shift;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q;
    logic               accept, last_step;

    always_comb begin
        acc_next     = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shift = mplier_q >> 1;
        accept       = start && (state_q != RUN);
        last_step    = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
        // No remaining multiplier bits means acc_next is already the final product.
        last_step    = last_step || (mplier_shift == '0);
`endif
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (accept) state_d = RUN;
            RUN:        if (last_step) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ab_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= '0;
                cnt_q    <= '0;
                done_q   <= 1'b0;
                busy_q   <= 1'b1;
            end else if (state_q == RUN) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_shift;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    ab_q   <= acc_next;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ab   = ab_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: an 8-bit instance for directed timing cases and a default-width instance for random products.
module tb_shift_add_multiplier;
    import elliptic_curve_structs::*;

    localparam int WD = P_WIDTH;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start8 = 1'b0;
    logic [7:0]      a8 = '0, b8 = '0;
    logic            busy8, done8;
    logic [15:0]     ab8;
    logic            startD = 1'b0;
    logic [WD-1:0]   aD = '0, bD = '0;
    logic            busyD, doneD;
    logic [2*WD-1:0] abD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .ab(ab8)
    );

    shift_add_multiplier uD (
        .clk(clk), .reset(reset), .start(startD), .a(aD), .b(bD),
        .busy(busyD), .done(doneD), .ab(abD)
    );

    // Reference latency: full width, or position of the top set bit of b when early termination is built in.
    function automatic int lat_of(input logic [WD-1:0] bv, input int w);
        int h = -1;
        for (int i = 0; i < w; i++) if (bv[i]) h = i;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
        return (h + 1 < 1) ? 1 : h + 1;
`else
        return w;
`endif
    endfunction

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, output int lat, output logic [15:0] prod);
        @(negedge clk); a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8) begin lat = i; break; end
        end
        prod = ab8;
    endtask

    task automatic runD(input logic [WD-1:0] av, input logic [WD-1:0] bv, output int lat, output logic [2*WD-1:0] prod);
        @(negedge clk); aD = av; bD = bv; startD = 1'b1;
        @(negedge clk); startD = 1'b0;
        lat = -1;
        for (int i = 1; i <= WD + 10; i++) begin
            @(negedge clk);
            if (doneD) begin lat = i; break; end
        end
        prod = abD;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy8, done8, ab8} !== 18'h0) begin
            errors++; $display("FAIL reset8: busy=%b done=%b ab=%h, expected all zero", busy8, done8, ab8);
        end
        checks++;
        if ({busyD, doneD, abD} !== {(2*WD+2){1'b0}}) begin
            errors++; $display("FAIL resetD: busy=%b done=%b ab=%h, expected all zero", busyD, doneD, abD);
        end
        reset = 1'b0;
    endtask

    task automatic test_ff();
        int lat = lat_of(WD'(8'hFF), 8);
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        checks++;
        if ({busy8, done8} !== 2'b10) begin
            errors++; $display("FAIL ff_accept: busy,done=%b expected 10", {busy8, done8});
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if ({busy8, done8} !== ((i >= lat) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL ff_timing cycle %0d: busy,done=%b expected %b", i, {busy8, done8}, (i >= lat) ? 2'b01 : 2'b10);
            end
        end
        checks++;
        if (ab8 !== 16'hFE01) begin
            errors++; $display("FAIL ff_product: ab=%h expected fe01", ab8);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({done8, ab8} !== {1'b1, 16'hFE01}) begin
                errors++; $display("FAIL ff_hold idle %0d: done=%b ab=%h expected 1 fe01", i, done8, ab8);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] p;
        run8(8'h12, 8'h34, lat, p);
        checks++;
        if (p !== 16'h03A8 || lat != lat_of(WD'(8'h34), 8)) begin
            errors++; $display("FAIL basic_12x34: ab=%h lat=%0d expected 03a8 lat=%0d", p, lat, lat_of(WD'(8'h34), 8));
        end
        run8(8'h00, 8'hA5, lat, p);
        checks++;
        if (p !== 16'h0000 || lat != lat_of(WD'(8'hA5), 8)) begin
            errors++; $display("FAIL basic_0xa5: ab=%h lat=%0d expected 0000 lat=%0d", p, lat, lat_of(WD'(8'hA5), 8));
        end
    endtask

    task automatic test_ignore_start();
        int lat = lat_of(WD'(8'd5), 8);
        int k = (lat > 3) ? 3 : 1;
        @(negedge clk); a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        for (int i = 1; i <= lat + 5; i++) begin
            @(negedge clk);
            checks++;
            if (i < lat) begin
                if (done8 !== 1'b0) begin
                    errors++; $display("FAIL ignore_run cycle %0d: done=%b expected 0", i, done8);
                end
            end else if ({done8, ab8} !== {1'b1, 16'h000F}) begin
                errors++; $display("FAIL ignore_result cycle %0d: done=%b ab=%h expected 1 000f", i, done8, ab8);
            end
            if (i == k) begin a8 = 8'd7; b8 = 8'd7; start8 = 1'b1; end
            else if (i == k + 1) start8 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int lat = lat_of(WD'(8'd9), 8);
        @(negedge clk); a8 = 8'd2; b8 = 8'd9; start8 = 1'b1;
        for (int i = 0; i <= 2 * lat + 2; i++) begin
            @(negedge clk);
            if (i == lat) begin
                checks++;
                if ({done8, ab8} !== {1'b1, 16'h0012}) begin
                    errors++; $display("FAIL b2b_first: done=%b ab=%h expected 1 0012", done8, ab8);
                end
            end
            if (i == lat + 1) begin
                checks++;
                if ({done8, busy8, ab8} !== {2'b01, 16'h0012}) begin
                    errors++; $display("FAIL b2b_reaccept: done=%b busy=%b ab=%h expected 0 1 0012", done8, busy8, ab8);
                end
                start8 = 1'b0;
            end
            if (i == 2 * lat) begin
                checks++;
                if ({done8, ab8} !== {1'b0, 16'h0012}) begin
                    errors++; $display("FAIL b2b_second_run: done=%b ab=%h expected 0 0012", done8, ab8);
                end
            end
            if (i == 2 * lat + 1) begin
                checks++;
                if ({done8, ab8} !== {1'b1, 16'h0012}) begin
                    errors++; $display("FAIL b2b_second: done=%b ab=%h expected 1 0012", done8, ab8);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] p;
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, ab8} !== 18'h0) begin
            errors++; $display("FAIL async_reset: busy=%b done=%b ab=%h expected all zero", busy8, done8, ab8);
        end
        @(negedge clk); reset = 1'b0;
        run8(8'h10, 8'h10, lat, p);
        checks++;
        if (p !== 16'h0100 || lat != lat_of(WD'(8'h10), 8)) begin
            errors++; $display("FAIL post_reset: ab=%h lat=%0d expected 0100 lat=%0d", p, lat, lat_of(WD'(8'h10), 8));
        end
    endtask

    task automatic test_early_term();
        int lat;
        logic [15:0] p;
        run8(8'hAB, 8'h01, lat, p);
        checks++;
        if (p !== 16'h00AB || lat != lat_of(WD'(8'h01), 8)) begin
            errors++; $display("FAIL early_b1: ab=%h lat=%0d expected 00ab lat=%0d", p, lat, lat_of(WD'(8'h01), 8));
        end
        run8(8'hAB, 8'h08, lat, p);
        checks++;
        if (p !== 16'h0558 || lat != lat_of(WD'(8'h08), 8)) begin
            errors++; $display("FAIL early_b8: ab=%h lat=%0d expected 0558 lat=%0d", p, lat, lat_of(WD'(8'h08), 8));
        end
        run8(8'hAB, 8'h00, lat, p);
        checks++;
        if (p !== 16'h0000 || lat != lat_of(WD'(8'h00), 8)) begin
            errors++; $display("FAIL early_b0: ab=%h lat=%0d expected 0000 lat=%0d", p, lat, lat_of(WD'(8'h00), 8));
        end
    endtask

    task automatic test_random_default();
        int lat;
        logic [2*WD-1:0] p, ea, eb, expv;
        logic [63:0] ra, rb;
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(0, 63);
            ea = (2*WD)'(WD'(ra));
            eb = (2*WD)'(WD'(rb));
            expv = ea * eb;
            runD(WD'(ra), WD'(rb), lat, p);
            checks++;
            if (p !== expv || lat != lat_of(WD'(rb), WD)) begin
                errors++;
                $display("FAIL random_%0d: ab=%h lat=%0d expected %h lat=%0d", n, p, lat, expv, lat_of(WD'(rb), WD));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ff();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        test_random_default();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
